pwm_multi: RTL

- Multi-channel PWM generator with a shared counter. Successor to the single-channel fixed-compare PWM block.
- Adds runtime-writable per-channel duty values, double-buffered so they take effect only at a period boundary, plus a clock prescaler and a global enable.
- Sits between control logic (SPI/serial command decoders) and LED or other on/off outputs.

---
 rtl/pwm_multi.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
//
// Multi-channel PWM generator. All channels share one prescaled counter.
// Each channel compares its active duty value against that counter.
//
// Duty writes land in a per-channel shadow register. A shadow value is copied
// into the channel's active register only at a period boundary (counter wrap).
// While the block is disabled, the copy happens every cycle instead.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        1 = run; 0 = hold prescaler/counter at 0 and force outputs low
//   div           prescaler: one counter tick every div+1 clocks
//   wr_en         duty write strobe
//   wr_ch         target channel (writes to channels >= CHANNELS are ignored)
//   wr_duty       new duty value
//   wr_ack        one-cycle pulse, the cycle after an accepted write
//   period_start  one-cycle pulse, the cycle after the counter wraps to 0
//   pwm           PWM outputs: pwm[i] = enable && (active[i] > ctr), registered
//   fade          (PWM_FADE_EN only) per-channel fade mode
//
// Optional feature, macro PWM_FADE_EN:
//   This macro adds the fade input. At each wrap, a fading channel moves its
//   active duty one step toward its shadow duty, instead of loading the shadow
//   directly. The same-cycle write bypass does not apply to fading channels.
//   While the block is disabled, fading channels still load the shadow
//   directly.
// ---------------------------------------------------------------------------
module pwm_multi #(
    parameter int CHANNELS  = 8,
    parameter int CTR_LEN   = 8,
    parameter int CH_ADDR_W = 3,
    parameter int DIV_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DIV_LEN-1:0]   div,
    input  logic                 wr_en,
    input  logic [CH_ADDR_W-1:0] wr_ch,
    input  logic [CTR_LEN-1:0]   wr_duty,
    output logic                 wr_ack,
    output logic                 period_start,
    output logic [CHANNELS-1:0]  pwm
`ifdef PWM_FADE_EN
    ,
    input  logic [CHANNELS-1:0]  fade
`endif
);

    localparam logic [CTR_LEN-1:0]   CTR_MAX  = {CTR_LEN{1'b1}};
    localparam logic [CH_ADDR_W:0]   CH_LIMIT = (CH_ADDR_W+1)'(CHANNELS);

`ifdef PWM_FADE_EN
    // One fade step: move cur one count toward tgt, or hold it if equal.
    function automatic logic [CTR_LEN-1:0] fade_step(
        input logic [CTR_LEN-1:0] cur,
        input logic [CTR_LEN-1:0] tgt
    );
        logic [CTR_LEN-1:0] res;
        if (cur < tgt) begin
            res = cur + {{(CTR_LEN-1){1'b0}}, 1'b1};
        end else if (cur > tgt) begin
            res = cur - {{(CTR_LEN-1){1'b0}}, 1'b1};
        end else begin
            res = cur;
        end
        return res;
    endfunction
`endif

    logic [DIV_LEN-1:0]  presc_r;
    logic [CTR_LEN-1:0]  ctr_r;
    logic [CTR_LEN-1:0]  shadow_r     [CHANNELS];
    logic [CTR_LEN-1:0]  active_r     [CHANNELS];
    logic [CTR_LEN-1:0]  shadow_nxt_s [CHANNELS];
    logic [CTR_LEN-1:0]  active_nxt_s [CHANNELS];
    logic                tick_s;
    logic                wrap_s;
    logic                wr_valid_s;
    logic [CHANNELS-1:0] pwm_nxt_s;

    // Tick/wrap/write-qualify decode.
    // The prescaler compare uses equality only. If div drops below presc_r,
    // the prescaler keeps counting, rolls over through its maximum value,
    // and meets the new div on the way back up.
    always_comb begin
        tick_s     = enable && (presc_r == div);
        wrap_s     = tick_s && (ctr_r == CTR_MAX);
        wr_valid_s = wr_en && ({1'b0, wr_ch} < CH_LIMIT);
    end

    // Next shadow values: the accepted write lands in its target channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_valid_s && (wr_ch == CH_ADDR_W'(i))) begin
                shadow_nxt_s[i] = wr_duty;
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Next active values.
    // The copy source is shadow_nxt_s, not shadow_r. A write in the same
    // cycle as a wrap, or while disabled, therefore takes effect immediately.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            active_nxt_s[i] = active_r[i];
            if (!enable) begin
                active_nxt_s[i] = shadow_nxt_s[i];
            end else if (wrap_s) begin
`ifdef PWM_FADE_EN
                if (fade[i]) begin
                    active_nxt_s[i] = fade_step(active_r[i], shadow_r[i]);
                end else begin
                    active_nxt_s[i] = shadow_nxt_s[i];
                end
`else
                active_nxt_s[i] = shadow_nxt_s[i];
`endif
            end else begin
                active_nxt_s[i] = active_r[i];
            end
        end
    end

    // Per-channel compare against the shared counter.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_nxt_s[i] = enable && (active_r[i] > ctr_r);
        end
    end

    // Prescaler and shared counter; both are held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {DIV_LEN{1'b0}};
            ctr_r   <= {CTR_LEN{1'b0}};
        end else if (!enable) begin
            presc_r <= {DIV_LEN{1'b0}};
            ctr_r   <= {CTR_LEN{1'b0}};
        end else if (tick_s) begin
            presc_r <= {DIV_LEN{1'b0}};
            ctr_r   <= ctr_r + {{(CTR_LEN-1){1'b0}}, 1'b1};
        end else begin
            presc_r <= presc_r + {{(DIV_LEN-1){1'b0}}, 1'b1};
            ctr_r   <= ctr_r;
        end
    end

    // Shadow and active duty registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_r[i] <= {CTR_LEN{1'b0}};
                active_r[i] <= {CTR_LEN{1'b0}};
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_r[i] <= shadow_nxt_s[i];
                active_r[i] <= active_nxt_s[i];
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm          <= {CHANNELS{1'b0}};
            wr_ack       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm          <= pwm_nxt_s;
            wr_ack       <= wr_valid_s;
            period_start <= wrap_s;
        end
    end

endmodule
